// File: rtl/tt_um_ay5876_dff_arbiter_if.sv
// Pin bundle of the arbiter tile: requester inputs, status/data outputs and the
// bidirectional bank that carries the transaction counter.
interface tt_um_ay5876_dff_arbiter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );
endinterface

// File: rtl/tt_um_ay5876_dff_arbiter.sv
// Round-robin arbiter guarding one shared storage flop: the granted requester
// writes its data bit into q each cycle until it drops req or its hold budget ends.
module tt_um_ay5876_dff_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_um_ay5876_dff_arbiter_if.slave     io
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_MAX - 1);

    state_t      state_q, state_d;
    logic        q_q, q_d;
    logic [3:0]  grant_q, grant_d;
    logic [2:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  txn_count_q, txn_count_d;

    logic [3:0]  req;
    logic [3:0]  din;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic        txn_done;

    assign req = io.ui_in[3:0];
    assign din = io.ui_in[7:4];

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    // last_q doubles as the current owner while in GRANT.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        grant_d     = grant_q;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        txn_count_d = txn_count_q;
        txn_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << pick_idx;
                    hold_cnt_d = 3'd0;
                    last_d     = pick_idx;
                end
            end
            GRANT: begin
                if (!req[last_q]) begin
                    txn_done = 1'b1;
                end else begin
                    q_d = din[last_q];
                    if (hold_cnt_q == HOLD_LAST) begin
                        txn_done = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (txn_done) begin
            state_d     = IDLE;
            grant_d     = 4'b0000;
            ptr_d       = last_q + 2'd1;
            txn_count_d = txn_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_q         <= 1'b0;
            grant_q     <= 4'b0000;
            hold_cnt_q  <= 3'd0;
            ptr_q       <= 2'd0;
            last_q      <= 2'd0;
            txn_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            grant_q     <= grant_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign io.uo_out  = {last_q, grant_q, ~q_q, q_q};
    assign io.uio_out = txn_count_q;
    assign io.uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, io.ena, io.uio_in};

endmodule

// File: tb/tb_tt_um_ay5876_dff_arbiter.sv
// Randomised and directed checks of the DFF arbiter against a cycle-level
// behavioural model of owners, grant lengths and the transaction count.
module tb_tt_um_ay5876_dff_arbiter;

    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    tt_um_ay5876_dff_arbiter_if bus ();

    tt_um_ay5876_dff_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner -1 means nobody holds the resource.
    int m_owner;
    int m_used;
    int m_ptr;
    int m_last;
    int m_txn;
    bit m_q;

    int cur_gidx;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_txn   = 0;
        m_q     = 1'b0;
    endtask

    task automatic model_finish();
        m_ptr   = (m_owner + 1) % 4;
        m_txn   = (m_txn + 1) % 256;
        m_owner = -1;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_used  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            model_finish();
        end else begin
            m_q = d[m_owner];
            if (m_used == HOLD_MAX) model_finish();
            else m_used++;
        end
    endtask

    function automatic logic [7:0] model_uo();
        logic [3:0] g;
        logic [1:0] l;
        g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        l = 2'(m_last);
        return {l, g, ~m_q, m_q};
    endfunction

    task automatic tick();
        logic [3:0] r;
        logic [3:0] d;
        r = bus.ui_in[3:0];
        d = bus.ui_in[7:4];
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_val("uo_out", bus.uo_out, model_uo());
        check_val("uio_out", bus.uio_out, 8'(m_txn));
        case (bus.uo_out[5:2])
            4'b0001: cur_gidx = 0;
            4'b0010: cur_gidx = 1;
            4'b0100: cur_gidx = 2;
            4'b1000: cur_gidx = 3;
            default: cur_gidx = -1;
        endcase
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d);
        bus.ui_in = {d, r};
    endtask

    // Assert reset away from a clock edge, check without any edge, then hold one edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_val({tag, "_uo"}, bus.uo_out, 8'h02);
        check_val({tag, "_uio"}, bus.uio_out, 8'h00);
        check_val({tag, "_oe"}, bus.uio_oe, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int g_idx[$];
    int g_len[$];
    int g_start[$];

    task automatic runs_clear();
        g_idx.delete();
        g_len.delete();
        g_start.delete();
    endtask

    task automatic runs_note(input int t, input int prev);
        if (cur_gidx >= 0) begin
            if (prev != cur_gidx) begin
                g_idx.push_back(cur_gidx);
                g_len.push_back(1);
                g_start.push_back(t);
            end else begin
                g_len[g_len.size() - 1]++;
            end
        end
    endtask

    initial begin
        int prev;
        int gcnt;
        int exp_order [5];
        logic [7:0] txn0;

        bus.ena    = 1'b1;
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h00;
        cur_gidx   = -1;
        model_reset();

        #2;
        do_reset("rst0");

        // Requester 0 writes a 1 twice, then releases.
        drive(4'h1, 4'h1);
        gcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.uo_out[5:2] == 4'b0001) gcnt++;
        end
        drive(4'h0, 4'h1);
        tick();
        check_val("s2_gcycles", 8'(gcnt), 8'd3);
        check_val("s2_q", {6'd0, bus.uo_out[1:0]}, 8'h01);
        check_val("s2_txn", bus.uio_out, 8'd1);
        check_val("s2_last", {6'd0, bus.uo_out[7:6]}, 8'd0);
        check_val("s2_grant", {4'd0, bus.uo_out[5:2]}, 8'd0);

        // Reset in the middle of a grant.
        drive(4'h1, 4'hF);
        tick();
        tick();
        check_val("s3_pre_grant", {4'd0, bus.uo_out[5:2]}, 8'h01);
        do_reset("s3_mid");

        // Everybody requesting: strict rotation, full-length grants.
        drive(4'hF, 4'h5);
        runs_clear();
        txn0 = bus.uio_out;
        prev = -1;
        for (int t = 0; t < 25; t++) begin
            tick();
            runs_note(t, prev);
            prev = cur_gidx;
        end
        exp_order = '{0, 1, 2, 3, 0};
        check_val("s4_nruns", 8'(g_idx.size()), 8'd5);
        for (int i = 0; i < 5 && i < g_idx.size(); i++) begin
            check_val($sformatf("s4_idx%0d", i), 8'(g_idx[i]), 8'(exp_order[i]));
            check_val($sformatf("s4_len%0d", i), 8'(g_len[i]), 8'(HOLD_MAX));
            if (i > 0)
                check_val($sformatf("s4_gap%0d", i),
                          8'(g_start[i] - g_start[i-1] - g_len[i-1]), 8'd1);
        end
        check_val("s4_txn", bus.uio_out - txn0, 8'd5);

        // After a grant to 0, requesters 0 and 2 together: 2 goes first.
        drive(4'b0101, 4'h0);
        runs_clear();
        prev = -1;
        for (int t = 0; t < 12; t++) begin
            tick();
            runs_note(t, prev);
            prev = cur_gidx;
        end
        check_val("s5_first", (g_idx.size() > 0) ? 8'(g_idx[0]) : 8'hEE, 8'd2);
        check_val("s5_second", (g_idx.size() > 1) ? 8'(g_idx[1]) : 8'hEE, 8'd0);
        drive(4'h0, 4'h0);
        for (int t = 0; t < 6; t++) tick();

        // Grant to 1: q follows din[1]; a late req[3] waits for arbitration.
        drive(4'b0010, 4'b0000);
        tick();
        check_val("s6_grant1", {4'd0, bus.uo_out[5:2]}, 8'b0010);
        drive(4'b0010, 4'b0000);
        tick();
        check_val("s6_q0", {7'd0, bus.uo_out[0]}, 8'd0);
        drive(4'b1010, 4'b0010);
        tick();
        check_val("s6_q1", {7'd0, bus.uo_out[0]}, 8'd1);
        check_val("s6_hold1", {4'd0, bus.uo_out[5:2]}, 8'b0010);
        drive(4'b1010, 4'b0000);
        tick();
        check_val("s6_q2", {7'd0, bus.uo_out[0]}, 8'd0);
        check_val("s6_hold2", {4'd0, bus.uo_out[5:2]}, 8'b0010);
        tick();
        check_val("s6_exit", {4'd0, bus.uo_out[5:2]}, 8'b0000);
        tick();
        check_val("s6_req3", {4'd0, bus.uo_out[5:2]}, 8'b1000);
        drive(4'h0, 4'h0);
        for (int t = 0; t < 6; t++) tick();

        // 256 one-cycle transactions wrap the counter.
        #2;
        do_reset("s7_rst");
        for (int n = 0; n < 256; n++) begin
            drive(4'h4, 4'h0);
            tick();
            drive(4'h0, 4'h0);
            tick();
            if (n == 254) check_val("s7_255", bus.uio_out, 8'hFF);
        end
        check_val("s7_wrap", bus.uio_out, 8'h00);

        // Random traffic against the model; requests tend to persist.
        for (int t = 0; t < 1500; t++) begin
            logic [3:0] r;
            r = bus.ui_in[3:0];
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
            drive(r, 4'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_ay5876_dff_arbiter.md
TT_UM_AY5876_DFF_ARBITER -- requirements
Module: tt_um_ay5876_dff_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, maximum consecutive grant cycles per transaction (legal 1..8).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock only.
REQ-004 ena  input  1  design-enable; ignored.
REQ-005 ui_in  input  8  [3:0] req[3:0] from four requesters; [7:4] din[3:0], requester i's data bit on din[i].
REQ-006 uo_out  output  8  [0] q, [1] ~q, [5:2] grant[3:0] one-hot, [7:6] last granted index.
REQ-007 uio_in  input  8  unused; terminated in an unused-signal reduction.
REQ-008 uio_out  output  8  txn_count[7:0], the completed-transaction counter.
REQ-009 uio_oe  output  8  constant 8'hFF.

Function
REQ-010 Shared resource: one storage flop q, written only by the currently granted requester.
REQ-011 Two-state FSM: IDLE, GRANT; all outputs registered except ~q, which derives from q.
REQ-012 IDLE, req==0: stay IDLE; grant=0; q holds.
REQ-013 IDLE, req!=0: round-robin pick g.
- Search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Next edge: GRANT, grant=onehot(g), hold_cnt=0, last=g.
REQ-014 GRANT, req[g]=1: q<=din[g] at each edge; hold_cnt increments.
REQ-015 GRANT exits to IDLE at the edge where either condition holds:
- req[g]=0 sampled; no capture on that edge.
- hold_cnt==HOLD_MAX-1; that edge still captures.
REQ-016 Grant duration per transaction: at most HOLD_MAX cycles.
REQ-017 Back-to-back grants: at least one IDLE cycle between them.
REQ-018 On every GRANT->IDLE edge:
- ptr<=(g+1) mod 4.
- txn_count<=txn_count+1, 8-bit wrap 255->0.
- grant<=0.
REQ-019 req changes on requesters other than g during GRANT: no effect until next IDLE arbitration.
REQ-020 din[g] change during GRANT: captured on the next edge, per REQ-014.
REQ-021 grant is one-hot or zero in every cycle.
REQ-022 last (uo_out[7:6]) holds its value through IDLE.

Reset
REQ-023 rst_n low, asynchronous, including mid-GRANT:
- state=IDLE, q=0, grant=0, hold_cnt=0, ptr=0, last=0, txn_count=0.
- Hence uo_out=8'h02, uio_out=8'h00, uio_oe=8'hFF.
REQ-024 First edge after rst_n rises: normal IDLE arbitration per REQ-013.

Verification
REQ-025 Bench covers these directed scenarios:
- Reset mid-GRANT (req=4'h1, din=4'hF), rst_n low -> uo_out=8'h02, uio_out=8'h00 without a clock edge.
- From reset, req=4'h1, din[0]=1 for 2 cycles, then req=0 -> grant0 for 3 cycles (2 captures, then drop edge), q=1 (uo_out[1:0]=2'b01), txn_count=1, last=0.
- All req=4'hF continuously, HOLD_MAX=4 -> grant order 0,1,2,3,0, each exactly 4 cycles, 1 IDLE cycle between, txn_count +1 per grant.
- After a grant to 0, req=4'b0101 simultaneously -> requester 2 granted first, then requester 0.
- During grant to 1, toggle din[1] 0,1,0 -> q follows with one-cycle latency; req[3] assertion has no effect until the next IDLE.
- 256 single-cycle transactions -> txn_count wraps to 8'h00.
